// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_universal
//  Description : Parametrised universal shift register with hold, shift
//                right, shift left and parallel load. Exposes the register
//                contents, a registered serial output, a per-word shift
//                counter and a one-cycle word-done strobe every WIDTH shifts,
//                so it can serve as a PISO serialiser or SIPO deserialiser.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_serial_in,
    input  logic [WIDTH-1:0] i_parallel_in,
    output logic [WIDTH-1:0] o_parallel_out,
    output logic             o_serial_out,
    output logic [CW-1:0]    o_count,
    output logic             o_word_done
);

    localparam logic [1:0]    C_MODE_HOLD  = 2'b00;
    localparam logic [1:0]    C_MODE_RIGHT = 2'b01;
    localparam logic [1:0]    C_MODE_LEFT  = 2'b10;
    localparam logic [1:0]    C_MODE_LOAD  = 2'b11;
    // Counter value on which the next shift completes a word.
    localparam logic [CW-1:0] C_LAST       = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_data;
    logic             r_serial;
    logic [CW-1:0]    r_count;
    logic             r_word_done;

    logic             w_last;
    logic [CW-1:0]    w_count_next;

    // Counter advance shared by both shift directions; wraps at the word end.
    always_comb begin
        w_last       = (r_count == C_LAST);
        w_count_next = w_last ? '0 : r_count + CW'(1);
    end

    // Register, serial output, counter and strobe; clear beats enable beats mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data      <= '0;
            r_serial    <= 1'b0;
            r_count     <= '0;
            r_word_done <= 1'b0;
        end else if (i_clear) begin
            r_data      <= '0;
            r_serial    <= 1'b0;
            r_count     <= '0;
            r_word_done <= 1'b0;
        end else if (!i_en) begin
            r_word_done <= 1'b0;
        end else begin
            case (i_mode)
                C_MODE_RIGHT: begin
                    r_data      <= {i_serial_in, r_data[WIDTH-1:1]};
                    r_serial    <= r_data[0];
                    r_count     <= w_count_next;
                    r_word_done <= w_last;
                end
                C_MODE_LEFT: begin
                    r_data      <= {r_data[WIDTH-2:0], i_serial_in};
                    r_serial    <= r_data[WIDTH-1];
                    r_count     <= w_count_next;
                    r_word_done <= w_last;
                end
                C_MODE_LOAD: begin
                    // A load starts a fresh word; the serial output keeps its last bit.
                    r_data      <= i_parallel_in;
                    r_count     <= '0;
                    r_word_done <= 1'b0;
                end
                C_MODE_HOLD: begin
                    r_word_done <= 1'b0;
                end
                default: begin
                    r_word_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_parallel_out = r_data;
    assign o_serial_out   = r_serial;
    assign o_count        = r_count;
    assign o_word_done    = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_universal
//  Description : Self-checking bench for shift_reg_universal (WIDTH=8 and
//                WIDTH=2 instances) using a behavioural model and a queue of
//                expected output words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_universal;

    logic       clk;
    logic       rst_n;

    // WIDTH=8 instance
    logic       clear, en, sin;
    logic [1:0] mode;
    logic [7:0] pin;
    logic [7:0] pout;
    logic       sout;
    logic [2:0] cnt;
    logic       done;

    // WIDTH=2 instance
    logic       clear2, en2, sin2;
    logic [1:0] mode2;
    logic [1:0] pin2;
    logic [1:0] pout2;
    logic       sout2;
    logic [0:0] cnt2;
    logic       done2;

    int checks;
    int errors;

    // Behavioural model state for the WIDTH=8 instance
    logic [7:0]  m_reg;
    logic        m_sout;
    logic [2:0]  m_cnt;
    logic        m_done;
    logic [12:0] sb[$];

    shift_reg_universal #(.WIDTH(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_en(en),
        .i_mode(mode), .i_serial_in(sin), .i_parallel_in(pin),
        .o_parallel_out(pout), .o_serial_out(sout), .o_count(cnt),
        .o_word_done(done)
    );

    shift_reg_universal #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear2), .i_en(en2),
        .i_mode(mode2), .i_serial_in(sin2), .i_parallel_in(pin2),
        .o_parallel_out(pout2), .o_serial_out(sout2), .o_count(cnt2),
        .o_word_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_reg  = '0;
        m_sout = 1'b0;
        m_cnt  = '0;
        m_done = 1'b0;
        sb.delete();
    endtask

    // Drive one edge on the WIDTH=8 DUT, advance the model and queue the expectation.
    task automatic edge8(input logic c, input logic e, input logic [1:0] md,
                         input logic s, input logic [7:0] p);
        clear = c; en = e; mode = md; sin = s; pin = p;
        if (c) begin
            m_reg = '0; m_sout = 1'b0; m_cnt = '0; m_done = 1'b0;
        end else if (!e) begin
            m_done = 1'b0;
        end else begin
            case (md)
                2'b01, 2'b10: begin
                    if (md == 2'b01) begin
                        m_sout = m_reg[0];
                        m_reg  = {s, m_reg[7:1]};
                    end else begin
                        m_sout = m_reg[7];
                        m_reg  = {m_reg[6:0], s};
                    end
                    if (m_cnt == 3'd7) begin
                        m_cnt = 3'd0; m_done = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 3'd1; m_done = 1'b0;
                    end
                end
                2'b11: begin
                    m_reg = p; m_cnt = 3'd0; m_done = 1'b0;
                end
                default: m_done = 1'b0;
            endcase
        end
        sb.push_back({m_reg, m_sout, m_cnt, m_done});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp, got;
        rst_n = 1'b0;
        clear = 0; en = 0; mode = 0; sin = 0; pin = 0;
        clear2 = 0; en2 = 0; mode2 = 0; sin2 = 0; pin2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({pout, sout, cnt, done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {pout, sout, cnt, done});
        end
        // Load all-ones, then pull reset between edges.
        edge8(0, 1, 2'b11, 0, 8'hFF);
        exp = sb.pop_front(); got = {pout, sout, cnt, done};
        checks++;
        if (got !== exp || pout !== 8'hFF) begin
            errors++;
            $display("FAIL load_ff: got %h expected %h", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pout, sout, cnt, done} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {pout, sout, cnt, done});
        end
        model_reset();
        rst_n = 1'b1;
        // Sync clear wins over enable + load of all-ones.
        edge8(0, 1, 2'b11, 0, 8'hFF);
        void'(sb.pop_front());
        edge8(0, 1, 2'b01, 1, 8'h00);
        void'(sb.pop_front());
        edge8(1, 1, 2'b11, 0, 8'hFF);
        exp = sb.pop_front(); got = {pout, sout, cnt, done};
        checks++;
        if (got !== exp || got !== 13'd0) begin
            errors++;
            $display("FAIL clear_priority: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_sipo_right();
        logic [7:0]  bits;
        logic [12:0] exp, got;
        int          pulses;
        bits = 8'b0100_1101;   // bit i is the i-th serial bit: 1,0,1,1,0,0,1,0
        pulses = 0;
        edge8(1, 0, 2'b00, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            edge8(0, 1, 2'b01, bits[i], 0);
            exp = sb.pop_front(); got = {pout, sout, cnt, done};
            if (done) pulses++;
            checks++;
            if (got !== exp || cnt !== 3'((i + 1) % 8)) begin
                errors++;
                $display("FAIL sipo_step%0d: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (pout !== 8'h4D || done !== 1'b1) begin
            errors++;
            $display("FAIL sipo_word: got %h/%b expected 4d/1", pout, done);
        end
        edge8(0, 1, 2'b00, 0, 0);
        exp = sb.pop_front(); got = {pout, sout, cnt, done};
        if (done) pulses++;
        checks++;
        if (got !== exp || pulses != 1) begin
            errors++;
            $display("FAIL sipo_pulse: got %h pulses %0d expected %h pulses 1", got, pulses, exp);
        end
    endtask

    task automatic test_piso_left();
        logic [7:0]  seq;
        logic [12:0] exp, got;
        seq = 8'b1010_0101;    // expected serial outputs MSB first
        edge8(0, 1, 2'b11, 0, 8'hA5);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            edge8(0, 1, 2'b10, 0, 0);
            exp = sb.pop_front(); got = {pout, sout, cnt, done};
            checks++;
            if (got !== exp || sout !== seq[7-i] || done !== (i == 7)) begin
                errors++;
                $display("FAIL piso_bit%0d: got %h expected %h (sout %b)", i, got, exp, seq[7-i]);
            end
        end
        checks++;
        if (pout !== 8'h00) begin
            errors++;
            $display("FAIL piso_final: got %h expected 00", pout);
        end
    endtask

    task automatic test_gating();
        logic [12:0] exp, got;
        int          step;
        edge8(1, 0, 2'b00, 0, 0);
        void'(sb.pop_front());
        step = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 3 || i >= 10) begin
                edge8(0, 1, 2'b01, 1'($urandom_range(1)), 0);
                step++;
            end else if (i < 8) begin
                edge8(0, 0, 2'b01, 1, 8'hFF);
            end else begin
                edge8(0, 1, 2'b00, 1, 8'hFF);
            end
            exp = sb.pop_front(); got = {pout, sout, cnt, done};
            checks++;
            if (got !== exp || done !== (step == 8 && (i >= 10))
                || (i >= 3 && i < 10 && cnt !== 3'd3)) begin
                errors++;
                $display("FAIL gating_cyc%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_load_mid();
        logic [12:0] exp, got;
        edge8(1, 0, 2'b00, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            edge8(0, 1, 2'b10, 1, 0);
            void'(sb.pop_front());
        end
        edge8(0, 1, 2'b11, 0, 8'h3C);
        exp = sb.pop_front(); got = {pout, sout, cnt, done};
        checks++;
        if (got !== exp || pout !== 8'h3C || cnt !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_mid: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 3; i++) begin
            edge8(0, 1, 2'b01, 0, 0);
            exp = sb.pop_front(); got = {pout, sout, cnt, done};
            checks++;
            if (got !== exp || done !== 1'b0) begin
                errors++;
                $display("FAIL load_mid_after%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // Mixed random traffic: direction changes mid-word, gaps, loads, clears.
    task automatic test_back_to_back();
        logic [12:0] exp, got;
        int          r;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(99));
            edge8(r < 2, r >= 10, (r < 40) ? 2'b01 : (r < 75) ? 2'b10 : (r < 88) ? 2'b00 : 2'b11,
                  1'($urandom_range(1)), 8'($urandom));
            exp = sb.pop_front(); got = {pout, sout, cnt, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cyc%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_width2();
        logic [1:0] exp_reg;
        clear2 = 1; en2 = 0; mode2 = 0; sin2 = 0; pin2 = 0;
        @(posedge clk); #1;
        clear2 = 0;
        exp_reg = 2'b00;
        for (int i = 0; i < 6; i++) begin
            en2 = 1; mode2 = 2'b01; sin2 = 1'(i % 3 == 0);
            exp_reg = {sin2, exp_reg[1]};
            @(posedge clk); #1;
            checks++;
            if (done2 !== (i % 2 == 1) || cnt2 !== 1'((i + 1) % 2) || pout2 !== exp_reg) begin
                errors++;
                $display("FAIL w2_shift%0d: got done %b cnt %b reg %b expected %b %b %b",
                         i, done2, cnt2, pout2, (i % 2 == 1), 1'((i + 1) % 2), exp_reg);
            end
        end
        en2 = 0;
        @(posedge clk); #1;
        checks++;
        if (done2 !== 1'b0) begin
            errors++;
            $display("FAIL w2_drop: got %b expected 0", done2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sipo_right();
        test_piso_left();
        test_gating();
        test_load_mid();
        test_back_to_back();
        test_width2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
